// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl
//   IEEE 1149.1 TAP controller for the jtag TDR chain. Contains the 16-state TAP
//   FSM, the instruction register, the BYPASS and IDCODE data registers, and the
//   decode that turns the current instruction into per-TDR strobes. Each TDR
//   reads its strobes as follows:
//     shift & capture = load scope inputs, shift alone = shift,
//     capture alone = update.
//   The selected TDR's serial output is muxed onto TDO.
//
// Ports
//   tck          test clock
//   trstb        test reset, asynchronous, active-low
//   tms          mode select, sampled on posedge tck
//   tdi          serial in, sampled on posedge tck
//   tdo          serial out, updated on negedge tck
//   tdo_en       TDO drive enable, updated on negedge tck
//   ir           current (updated) instruction
//   tdr_si       serial data to every TDR (copy of tdi)
//   tdr_so       serial output of each TDR
//   tdr_shift    per-TDR shift strobe
//   tdr_capture  per-TDR capture/update strobe
//   tdr_select   per-TDR sticky config-override enable
module jtag_tap_ctrl #(
    parameter int          IR_W   = 4,
    parameter int          N_TDR  = 4,
    parameter logic [31:0] IDCODE = 32'h0000_0001
) (
    input  logic             tck,
    input  logic             trstb,
    input  logic             tms,
    input  logic             tdi,
    output logic             tdo,
    output logic             tdo_en,
    output logic [IR_W-1:0]  ir,
    output logic             tdr_si,
    input  logic [N_TDR-1:0] tdr_so,
    output logic [N_TDR-1:0] tdr_shift,
    output logic [N_TDR-1:0] tdr_capture,
    output logic [N_TDR-1:0] tdr_select
);

    // Standard 1149.1 state encoding.
    localparam logic [3:0] ST_EX2DR = 4'h0;
    localparam logic [3:0] ST_EX1DR = 4'h1;
    localparam logic [3:0] ST_SHDR  = 4'h2;
    localparam logic [3:0] ST_PDR   = 4'h3;
    localparam logic [3:0] ST_SELIR = 4'h4;
    localparam logic [3:0] ST_UPDR  = 4'h5;
    localparam logic [3:0] ST_CAPDR = 4'h6;
    localparam logic [3:0] ST_SELDR = 4'h7;
    localparam logic [3:0] ST_EX2IR = 4'h8;
    localparam logic [3:0] ST_EX1IR = 4'h9;
    localparam logic [3:0] ST_SHIR  = 4'hA;
    localparam logic [3:0] ST_PIR   = 4'hB;
    localparam logic [3:0] ST_RTI   = 4'hC;
    localparam logic [3:0] ST_UPIR  = 4'hD;
    localparam logic [3:0] ST_CAPIR = 4'hE;
    localparam logic [3:0] ST_TLR   = 4'hF;

    localparam logic [IR_W-1:0] IR_CAPTURE = {{(IR_W-2){1'b0}}, 2'b01};

    logic [3:0]       state;
    logic [3:0]       state_next;
    logic [IR_W-1:0]  ir_shift;
    logic             bypass_reg;
    logic [31:0]      idcode_reg;
    logic [N_TDR-1:0] tdr_onehot;
    logic             tdr_hit;
    logic             is_idcode;
    logic             is_bypass;
    logic             dr_out;
    logic             enter_tlr;

    always_comb begin
        state_next = ST_TLR;
        case (state)
            ST_TLR:   state_next = tms ? ST_TLR   : ST_RTI;
            ST_RTI:   state_next = tms ? ST_SELDR : ST_RTI;
            ST_SELDR: state_next = tms ? ST_SELIR : ST_CAPDR;
            ST_CAPDR: state_next = tms ? ST_EX1DR : ST_SHDR;
            ST_SHDR:  state_next = tms ? ST_EX1DR : ST_SHDR;
            ST_EX1DR: state_next = tms ? ST_UPDR  : ST_PDR;
            ST_PDR:   state_next = tms ? ST_EX2DR : ST_PDR;
            ST_EX2DR: state_next = tms ? ST_UPDR  : ST_SHDR;
            ST_UPDR:  state_next = tms ? ST_SELDR : ST_RTI;
            ST_SELIR: state_next = tms ? ST_TLR   : ST_CAPIR;
            ST_CAPIR: state_next = tms ? ST_EX1IR : ST_SHIR;
            ST_SHIR:  state_next = tms ? ST_EX1IR : ST_SHIR;
            ST_EX1IR: state_next = tms ? ST_UPIR  : ST_PIR;
            ST_PIR:   state_next = tms ? ST_EX2IR : ST_PIR;
            ST_EX2IR: state_next = tms ? ST_UPIR  : ST_SHIR;
            ST_UPIR:  state_next = tms ? ST_SELDR : ST_RTI;
            default:  state_next = ST_TLR;
        endcase
    end

    // Clearing on the edge that enters TEST_LOGIC_RESET makes the state behave
    // exactly like trstb from its first cycle onward.
    assign enter_tlr = (state_next == ST_TLR);

    always_ff @(posedge tck or negedge trstb) begin
        if (!trstb) begin
            state <= ST_TLR;
        end else begin
            state <= state_next;
        end
    end

    // Instruction decode. ir only moves in UPDATE_IR, so decoding it directly
    // gives the instruction that was current at CAPTURE_DR entry.
    always_comb begin
        tdr_onehot = '0;
        for (int k = 0; k < N_TDR; k++) begin
            if (ir == IR_W'(k + 1)) begin
                tdr_onehot[k] = 1'b1;
            end
        end
    end

    assign tdr_hit   = |tdr_onehot;
    assign is_idcode = (ir == '0);
    assign is_bypass = !is_idcode && !tdr_hit;

    assign tdr_si      = tdi;
    assign tdr_shift   = ((state == ST_CAPDR) || (state == ST_SHDR)) ? tdr_onehot : '0;
    assign tdr_capture = ((state == ST_CAPDR) || (state == ST_UPDR)) ? tdr_onehot : '0;

    always_ff @(posedge tck or negedge trstb) begin
        if (!trstb) begin
            ir_shift <= '0;
            ir       <= '0;
        end else begin
            if (state == ST_CAPIR) begin
                ir_shift <= IR_CAPTURE;
            end else if (state == ST_SHIR) begin
                ir_shift <= {tdi, ir_shift[IR_W-1:1]};
            end
            if (enter_tlr) begin
                ir <= '0;
            end else if (state == ST_UPIR) begin
                ir <= ir_shift;
            end
        end
    end

    // tdr_select bits are sticky: only reset or TEST_LOGIC_RESET clears them.
    always_ff @(posedge tck or negedge trstb) begin
        if (!trstb) begin
            tdr_select <= '0;
        end else if (enter_tlr) begin
            tdr_select <= '0;
        end else if (state == ST_UPDR) begin
            tdr_select <= tdr_select | tdr_onehot;
        end
    end

    always_ff @(posedge tck or negedge trstb) begin
        if (!trstb) begin
            bypass_reg <= 1'b0;
            idcode_reg <= IDCODE;
        end else if (enter_tlr) begin
            bypass_reg <= 1'b0;
            idcode_reg <= IDCODE;
        end else begin
            if (is_bypass && (state == ST_CAPDR)) begin
                bypass_reg <= 1'b0;
            end else if (is_bypass && (state == ST_SHDR)) begin
                bypass_reg <= tdi;
            end
            if (is_idcode && (state == ST_CAPDR)) begin
                idcode_reg <= IDCODE;
            end else if (is_idcode && (state == ST_SHDR)) begin
                idcode_reg <= {tdi, idcode_reg[31:1]};
            end
        end
    end

    always_comb begin
        dr_out = bypass_reg;
        if (tdr_hit) begin
            dr_out = |(tdr_so & tdr_onehot);
        end else if (is_idcode) begin
            dr_out = idcode_reg[0];
        end
    end

    // TDO changes on the falling edge so the far end samples it cleanly on the
    // next rising edge. Outside the shift states it holds its last value.
    always_ff @(negedge tck or negedge trstb) begin
        if (!trstb) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            case (state)
                ST_SHIR: begin
                    tdo    <= ir_shift[0];
                    tdo_en <= 1'b1;
                end
                ST_SHDR: begin
                    tdo    <= dr_out;
                    tdo_en <= 1'b1;
                end
                ST_TLR: begin
                    tdo    <= 1'b0;
                    tdo_en <= 1'b0;
                end
                default: begin
                    tdo_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl
//   Self-checking bench for jtag_tap_ctrl. A reference TAP model tracks state,
//   instruction and sticky selects; expected TDO bits are queued when a scan is
//   set up and popped every cycle the model is in a shift state. Four small
//   TDR models hang on the strobes so loads, shifts and updates are visible.
module tb_jtag_tap_ctrl;

    localparam int IR_W  = 4;
    localparam int N_TDR = 4;

    logic             tck = 1'b0;
    logic             trstb;
    logic             tms;
    logic             tdi;
    logic             tdo;
    logic             tdo_en;
    logic [IR_W-1:0]  ir;
    logic             tdr_si;
    logic [N_TDR-1:0] tdr_so;
    logic [N_TDR-1:0] tdr_shift;
    logic [N_TDR-1:0] tdr_capture;
    logic [N_TDR-1:0] tdr_select;

    jtag_tap_ctrl #(
        .IR_W   (IR_W),
        .N_TDR  (N_TDR),
        .IDCODE (32'h0000_0001)
    ) dut (
        .tck         (tck),
        .trstb       (trstb),
        .tms         (tms),
        .tdi         (tdi),
        .tdo         (tdo),
        .tdo_en      (tdo_en),
        .ir          (ir),
        .tdr_si      (tdr_si),
        .tdr_so      (tdr_so),
        .tdr_shift   (tdr_shift),
        .tdr_capture (tdr_capture),
        .tdr_select  (tdr_select)
    );

    always #5 tck = ~tck;

    typedef enum logic [3:0] {
        M_TLR, M_RTI, M_SELDR, M_CAPDR, M_SHDR, M_EX1DR, M_PDR, M_EX2DR,
        M_UPDR, M_SELIR, M_CAPIR, M_SHIR, M_EX1IR, M_PIR, M_EX2IR, M_UPIR
    } mstate_t;

    mstate_t    ms;
    logic [3:0] m_ir;
    logic [3:0] m_irsh;
    logic [3:0] m_sel;
    bit         exp_q[$];
    int         tests_run;
    int         tests_failed;

    // Simple TDR models: 8-bit shift register plus update shadow.
    logic [7:0] tdr_reg    [N_TDR] = '{default: 8'h00};
    logic [7:0] tdr_shadow [N_TDR] = '{default: 8'h00};

    function automatic logic [7:0] tdr_load(input int k);
        case (k)
            0:       tdr_load = 8'hC3;
            1:       tdr_load = 8'hD2;
            2:       tdr_load = 8'hE1;
            default: tdr_load = 8'hF0;
        endcase
    endfunction

    always @(posedge tck) begin
        for (int k = 0; k < N_TDR; k++) begin
            if (tdr_shift[k] && tdr_capture[k]) begin
                tdr_reg[k] <= tdr_load(k);
            end else if (tdr_shift[k]) begin
                tdr_reg[k] <= {tdr_si, tdr_reg[k][7:1]};
            end else if (tdr_capture[k]) begin
                tdr_shadow[k] <= tdr_reg[k];
            end
        end
    end

    always_comb begin
        tdr_so = '0;
        for (int k = 0; k < N_TDR; k++) begin
            tdr_so[k] = tdr_reg[k][0];
        end
    end

    function automatic mstate_t model_next(input mstate_t s, input logic t);
        case (s)
            M_TLR:   model_next = t ? M_TLR   : M_RTI;
            M_RTI:   model_next = t ? M_SELDR : M_RTI;
            M_SELDR: model_next = t ? M_SELIR : M_CAPDR;
            M_CAPDR: model_next = t ? M_EX1DR : M_SHDR;
            M_SHDR:  model_next = t ? M_EX1DR : M_SHDR;
            M_EX1DR: model_next = t ? M_UPDR  : M_PDR;
            M_PDR:   model_next = t ? M_EX2DR : M_PDR;
            M_EX2DR: model_next = t ? M_UPDR  : M_SHDR;
            M_UPDR:  model_next = t ? M_SELDR : M_RTI;
            M_SELIR: model_next = t ? M_TLR   : M_CAPIR;
            M_CAPIR: model_next = t ? M_EX1IR : M_SHIR;
            M_SHIR:  model_next = t ? M_EX1IR : M_SHIR;
            M_EX1IR: model_next = t ? M_UPIR  : M_PIR;
            M_PIR:   model_next = t ? M_EX2IR : M_PIR;
            M_EX2IR: model_next = t ? M_UPIR  : M_SHIR;
            default: model_next = t ? M_SELDR : M_RTI;
        endcase
    endfunction

    function automatic logic [3:0] m_onehot(input logic [3:0] code);
        if (code >= 4'd1 && code <= 4'(N_TDR)) begin
            m_onehot = 4'b0001 << (code - 4'd1);
        end else begin
            m_onehot = 4'b0000;
        end
    endfunction

    task automatic push_bits(input int n, input logic [31:0] v);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(v[i]);
        end
    endtask

    // One tck: drive inputs after the falling edge, advance the model at the
    // rising edge, then check everything just after the next falling edge.
    task automatic tick(input logic tms_v, input logic tdi_v);
        logic [3:0] oh;
        logic [3:0] exp_sh;
        logic [3:0] exp_cap;
        logic       exp_en;
        bit         exp_bit;
        tms = tms_v;
        tdi = tdi_v;
        @(posedge tck);
        if (ms == M_CAPIR) begin
            m_irsh = 4'b0001;
        end else if (ms == M_SHIR) begin
            m_irsh = {tdi_v, m_irsh[3:1]};
        end
        if (ms == M_UPIR) m_ir = m_irsh;
        if (ms == M_UPDR) m_sel = m_sel | m_onehot(m_ir);
        ms = model_next(ms, tms_v);
        if (ms == M_TLR) begin
            m_ir  = 4'h0;
            m_sel = 4'h0;
        end
        @(negedge tck);
        #1;
        oh      = m_onehot(m_ir);
        exp_en  = (ms == M_SHDR) || (ms == M_SHIR);
        exp_sh  = ((ms == M_CAPDR) || (ms == M_SHDR)) ? oh : 4'h0;
        exp_cap = ((ms == M_CAPDR) || (ms == M_UPDR)) ? oh : 4'h0;
        tests_run++;
        if (tdo_en !== exp_en) begin
            tests_failed++;
            $display("[TB] FAIL tdo_en state=%s got=%b want=%b", ms.name(), tdo_en, exp_en);
        end
        tests_run++;
        if (tdr_shift !== exp_sh) begin
            tests_failed++;
            $display("[TB] FAIL tdr_shift state=%s got=%b want=%b", ms.name(), tdr_shift, exp_sh);
        end
        tests_run++;
        if (tdr_capture !== exp_cap) begin
            tests_failed++;
            $display("[TB] FAIL tdr_capture state=%s got=%b want=%b", ms.name(), tdr_capture, exp_cap);
        end
        tests_run++;
        if (tdr_select !== m_sel) begin
            tests_failed++;
            $display("[TB] FAIL tdr_select state=%s got=%b want=%b", ms.name(), tdr_select, m_sel);
        end
        tests_run++;
        if (ir !== m_ir) begin
            tests_failed++;
            $display("[TB] FAIL ir state=%s got=%h want=%h", ms.name(), ir, m_ir);
        end
        if (exp_en) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL scoreboard underflow state=%s tdo=%b", ms.name(), tdo);
            end else begin
                exp_bit = exp_q.pop_front();
                if (tdo !== exp_bit) begin
                    tests_failed++;
                    $display("[TB] FAIL tdo state=%s got=%b want=%b", ms.name(), tdo, exp_bit);
                end
            end
        end
    endtask

    // IR scan from RUN_TEST_IDLE back to RUN_TEST_IDLE.
    task automatic ir_scan(input logic [3:0] code);
        push_bits(4, 32'h0000_0001);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(i == 3, code[i]);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    // DR scan from RUN_TEST_IDLE; pause_at > 0 inserts a three-cycle pause
    // after that many bits. Caller queues the expected TDO bits.
    task automatic dr_scan(input int n, input logic [31:0] din, input int pause_at);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            tick((i == n - 1) || (i == pause_at - 1), din[i]);
            if ((i == pause_at - 1) && (i != n - 1)) begin
                tick(1'b0, 1'b1);
                tick(1'b0, 1'b1);
                tick(1'b0, 1'b1);
                tick(1'b1, 1'b1);
                tick(1'b0, 1'b1);
            end
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        trstb = 1'b0;
        tms   = 1'b1;
        tdi   = 1'b0;
        repeat (2) @(negedge tck);
        #1;
        tests_run++;
        if ({ir, tdr_select, tdo, tdo_en} !== 10'h000) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs got ir=%h sel=%b tdo=%b en=%b want all 0", ir, tdr_select, tdo, tdo_en);
        end
        tests_run++;
        if ({tdr_shift, tdr_capture} !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL reset_strobes got sh=%b cap=%b want 0", tdr_shift, tdr_capture);
        end
        trstb  = 1'b1;
        ms     = M_TLR;
        m_ir   = 4'h0;
        m_irsh = 4'h0;
        m_sel  = 4'h0;
        repeat (5) tick(1'b1, 1'b0);
        tests_run++;
        if ({ir, tdr_select, tdo_en} !== 9'h000) begin
            tests_failed++;
            $display("[TB] FAIL tms_reset got ir=%h sel=%b en=%b want 0", ir, tdr_select, tdo_en);
        end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_idcode();
        push_bits(32, 32'h0000_0001);
        dr_scan(32, 32'hDEAD_BEEF, 0);
    endtask

    task automatic test_tdr_scan();
        ir_scan(4'h2);
        push_bits(8, {24'h0, tdr_load(1)});
        dr_scan(8, 32'h0000_00A7, 0);
        tests_run++;
        if (tdr_select !== 4'b0010) begin
            tests_failed++;
            $display("[TB] FAIL tdr_select_after_update got=%b want=0010", tdr_select);
        end
        tests_run++;
        if (tdr_shadow[1] !== 8'hA7) begin
            tests_failed++;
            $display("[TB] FAIL tdr1_update got=%h want=a7", tdr_shadow[1]);
        end
    endtask

    task automatic test_pause();
        push_bits(8, {24'h0, tdr_load(1)});
        dr_scan(8, 32'h0000_003C, 3);
        tests_run++;
        if (tdr_shadow[1] !== 8'h3C) begin
            tests_failed++;
            $display("[TB] FAIL pause_update got=%h want=3c", tdr_shadow[1]);
        end
    endtask

    task automatic test_bypass();
        ir_scan(4'hF);
        push_bits(9, 32'h0000_014A);
        dr_scan(9, 32'h0000_00A5, 0);
    endtask

    task automatic test_back_to_back();
        ir_scan(4'h1);
        push_bits(8, {24'h0, tdr_load(0)});
        dr_scan(8, 32'h0000_005A, 0);
        push_bits(8, {24'h0, tdr_load(0)});
        dr_scan(8, 32'h0000_0096, 0);
        tests_run++;
        if (tdr_shadow[0] !== 8'h96) begin
            tests_failed++;
            $display("[TB] FAIL b2b_update got=%h want=96", tdr_shadow[0]);
        end
        tests_run++;
        if (tdr_select !== 4'b0011) begin
            tests_failed++;
            $display("[TB] FAIL b2b_select got=%b want=0011", tdr_select);
        end
    endtask

    task automatic test_tms_reset();
        logic [7:0] ld;
        ld = tdr_load(0);
        push_bits(1, {31'h0, ld[0]});
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        repeat (5) tick(1'b1, 1'b0);
        tests_run++;
        if ({ir, tdr_select, tdo_en} !== 9'h000) begin
            tests_failed++;
            $display("[TB] FAIL tms_reset_midscan got ir=%h sel=%b en=%b want 0", ir, tdr_select, tdo_en);
        end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_trst_midscan();
        logic [7:0] shadow_before;
        ir_scan(4'h3);
        push_bits(3, {24'h0, tdr_load(2)});
        shadow_before = tdr_shadow[2];
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        trstb = 1'b0;
        #1;
        tests_run++;
        if ({ir, tdr_capture, tdr_shift, tdr_select} !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL trst_midscan got ir=%h cap=%b sh=%b sel=%b want 0", ir, tdr_capture, tdr_shift, tdr_select);
        end
        tests_run++;
        if ({tdo, tdo_en} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL trst_tdo got tdo=%b en=%b want 0", tdo, tdo_en);
        end
        @(negedge tck);
        #1;
        tests_run++;
        if (tdr_shadow[2] !== shadow_before) begin
            tests_failed++;
            $display("[TB] FAIL trst_no_update got=%h want=%h", tdr_shadow[2], shadow_before);
        end
        trstb = 1'b1;
        ms    = M_TLR;
        m_ir  = 4'h0;
        m_sel = 4'h0;
        tick(1'b0, 1'b0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        trstb = 1'b0;
        tms   = 1'b1;
        tdi   = 1'b0;
        ms    = M_TLR;
        m_ir  = 4'h0;
        m_irsh = 4'h0;
        m_sel = 4'h0;
        test_reset();
        test_idcode();
        test_tdr_scan();
        test_pause();
        test_bypass();
        test_back_to_back();
        test_tms_reset();
        test_trst_midscan();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

endmodule
